// File: rtl/uart_tx_fifo_if.sv
// CSR write port feeding the UART transmit FIFO.
// The core side drives it as master; the UART block receives it as slave.
interface uart_tx_fifo_if;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [7:0]  csr_data;

  modport master (output csr_we, output csr_addr, output csr_data);
  modport slave  (input  csr_we, input  csr_addr, input  csr_data);
endinterface

// File: rtl/uart_tx_fifo.sv
// CSR-fed UART transmitter: byte FIFO plus an 8N1 serialiser.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_fifo #(
  parameter int unsigned QueueSize = 32,
  parameter int unsigned PtrWidth  = $clog2(QueueSize),
  parameter logic [11:0] CsrAddr   = 12'h050,
  parameter int unsigned CmpVal    = 173
) (
  input  logic                clk,
  input  logic                reset_n,
  uart_tx_fifo_if.slave       csr,
  output logic                tx,
  output logic                busy,
  output logic                fifo_full,
  output logic                fifo_empty,
  output logic [PtrWidth:0]   fifo_level,
  output logic                overflow
);

  localparam int unsigned BaudW = (CmpVal > 1) ? $clog2(CmpVal) : 1;
  localparam logic [BaudW-1:0]  BaudLast  = BaudW'(CmpVal - 1);
  localparam logic [PtrWidth:0] LevelFull = (PtrWidth + 1)'(QueueSize);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;
`endif

  state_t              r_state;
  state_t              w_state_next;
  logic [7:0]          r_mem [QueueSize];
  logic [PtrWidth-1:0] r_wr_ptr;
  logic [PtrWidth-1:0] r_rd_ptr;
  logic [PtrWidth:0]   r_count;
  logic [PtrWidth:0]   w_count_next;
  logic                r_full;
  logic                r_empty;
  logic                r_overflow;
  logic [BaudW-1:0]    r_baud;
  logic [BaudW-1:0]    w_baud_next;
  logic [2:0]          r_bit;
  logic [2:0]          w_bit_next;
  logic [7:0]          r_shift;
  logic [7:0]          w_shift_next;
  logic                r_tx;
  logic                w_tx_next;
  logic                w_tick;
  logic                w_push_req;
  logic                w_push;
  logic                w_pop;
`ifdef UART_TX_PARITY_EN
  logic                r_par;
`endif

  assign w_push_req = csr.csr_we && (csr.csr_addr == CsrAddr);
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign w_push     = w_push_req && (!r_full || w_pop);
  assign w_tick     = (r_baud == BaudLast);

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= csr.csr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push_req && !w_push) begin
        r_overflow <= 1'b1;
      end
      r_count <= w_count_next;
      r_full  <= (w_count_next == LevelFull);
      r_empty <= (w_count_next == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_baud  <= w_baud_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
      r_tx    <= w_tx_next;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_par <= 1'b0;
    end else if (w_pop) begin
      r_par <= ^r_mem[r_rd_ptr];
    end
  end
`endif

  always_comb begin
    w_state_next = r_state;
    w_baud_next  = r_baud;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_pop        = 1'b0;
    w_tx_next    = 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (!r_empty) begin
          w_pop        = 1'b1;
          w_baud_next  = '0;
          w_bit_next   = '0;
          w_shift_next = r_mem[r_rd_ptr];
          w_state_next = ST_START;
        end
      end
      ST_START: begin
        if (w_tick) begin
          w_baud_next  = '0;
          w_bit_next   = '0;
          w_state_next = ST_DATA;
        end else begin
          w_baud_next = r_baud + 1'b1;
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          w_baud_next  = '0;
          w_shift_next = {1'b0, r_shift[7:1]};
          if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            w_state_next = ST_PARITY;
`else
            w_state_next = ST_STOP;
`endif
          end else begin
            w_bit_next = r_bit + 1'b1;
          end
        end else begin
          w_baud_next = r_baud + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (w_tick) begin
          w_baud_next  = '0;
          w_state_next = ST_STOP;
        end else begin
          w_baud_next = r_baud + 1'b1;
        end
      end
`endif
      ST_STOP: begin
        if (w_tick) begin
          w_baud_next = '0;
          if (!r_empty) begin
            w_pop        = 1'b1;
            w_bit_next   = '0;
            w_shift_next = r_mem[r_rd_ptr];
            w_state_next = ST_START;
          end else begin
            w_state_next = ST_IDLE;
          end
        end else begin
          w_baud_next = r_baud + 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    // tx is registered, so it is derived from where the FSM will be after this edge.
    case (w_state_next)
      ST_START:  w_tx_next = 1'b0;
      ST_DATA:   w_tx_next = w_shift_next[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: w_tx_next = r_par;
`endif
      default:   w_tx_next = 1'b1;
    endcase
  end

  assign tx         = r_tx;
  assign busy       = (r_state != ST_IDLE);
  assign fifo_full  = r_full;
  assign fifo_empty = r_empty;
  assign fifo_level = r_count;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a 4-cycle bit period; frames are captured
// cycle by cycle and compared against bench-built waveforms.
module tb_uart_tx_fifo;

  localparam int unsigned CMP = 4;
`ifdef UART_TX_PARITY_EN
  localparam int unsigned FB = 11;
`else
  localparam int unsigned FB = 10;
`endif

  logic       clk;
  logic       reset_n;
  logic       tx;
  logic       busy;
  logic       fifo_full;
  logic       fifo_empty;
  logic [5:0] fifo_level;
  logic       overflow;

  int unsigned n_checks;
  int unsigned n_errors;

  uart_tx_fifo_if u_if ();

  uart_tx_fifo #(
    .QueueSize (32),
    .CsrAddr   (12'h050),
    .CmpVal    (CMP)
  ) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .csr        (u_if.slave),
    .tx         (tx),
    .busy       (busy),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [7:0] d, input logic we);
    u_if.csr_we   = we;
    u_if.csr_addr = a;
    u_if.csr_data = d;
    tick();
    u_if.csr_we = 1'b0;
  endtask

  function automatic logic [63:0] expand(input logic [7:0] d);
    logic [10:0] bits;
    logic [63:0] r;
    bits      = '0;
    bits[0]   = 1'b0;
    bits[8:1] = d;
`ifdef UART_TX_PARITY_EN
    bits[9]   = ^d;
    bits[10]  = 1'b1;
`else
    bits[9]   = 1'b1;
`endif
    r = '0;
    for (int b = 0; b < int'(FB); b++)
      for (int c = 0; c < int'(CMP); c++)
        r[b*CMP + c] = bits[b];
    return r;
  endfunction

  // Called at the first cycle of a frame's start bit; returns at the first cycle after its stop bit.
  task automatic frame(input string tag, input logic [7:0] d);
    logic [63:0] cap;
    int unsigned nbusy;
    cap   = '0;
    nbusy = 0;
    for (int i = 0; i < int'(FB*CMP); i++) begin
      cap[i] = tx;
      if (busy) nbusy++;
      tick();
    end
    check({tag, "_tx"}, cap, expand(d));
    check({tag, "_busy"}, 64'(nbusy), 64'(FB*CMP));
  endtask

  function automatic logic [7:0] pat(input int unsigned j);
    return 8'(j * 29 + 3);
  endfunction

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    reset_n       = 1'b0;
    u_if.csr_we   = 1'b0;
    u_if.csr_addr = '0;
    u_if.csr_data = '0;
    tick();
    tick();
    check("rst_tx", 64'(tx), 1);
    check("rst_busy", 64'(busy), 0);
    check("rst_full", 64'(fifo_full), 0);
    check("rst_empty", 64'(fifo_empty), 1);
    check("rst_level", 64'(fifo_level), 0);
    check("rst_ovf", 64'(overflow), 0);
    reset_n = 1'b1;
    tick();

    // Single byte from idle
    csr_write(12'h050, 8'hA5, 1'b1);
    check("t1_empty", 64'(fifo_empty), 0);
    check("t1_level", 64'(fifo_level), 1);
    check("t1_tx_pre", 64'(tx), 1);
    tick();
    check("t1_level_pop", 64'(fifo_level), 0);
    frame("t1_A5", 8'hA5);
    check("t1_busy_end", 64'(busy), 0);
    check("t1_tx_end", 64'(tx), 1);

    // Back-to-back frames
    csr_write(12'h050, 8'h55, 1'b1);
    check("t2_level_a", 64'(fifo_level), 1);
    csr_write(12'h050, 8'h0F, 1'b1);
    check("t2_level_b", 64'(fifo_level), 1);
    frame("t2_55", 8'h55);
    check("t2_level_c", 64'(fifo_level), 0);
    frame("t2_0F", 8'h0F);
    check("t2_busy_end", 64'(busy), 0);
    check("t2_tx_end", 64'(tx), 1);

    // Writes that must not push
    csr_write(12'h051, 8'hAA, 1'b1);
    csr_write(12'h050, 8'hBB, 1'b0);
    tick();
    check("t5_empty", 64'(fifo_empty), 1);
    check("t5_level", 64'(fifo_level), 0);
    check("t5_tx", 64'(tx), 1);
    check("t5_busy", 64'(busy), 0);

    // Fill past full while busy
    csr_write(12'h050, 8'hC3, 1'b1);
    tick();
    check("t3_busy", 64'(busy), 1);
    for (int j = 0; j < 33; j++) csr_write(12'h050, pat(j), 1'b1);
    check("t3_level", 64'(fifo_level), 32);
    check("t3_full", 64'(fifo_full), 1);
    check("t3_ovf", 64'(overflow), 1);
    repeat (7) tick();
    check("t3_level_pop", 64'(fifo_level), 31);
    check("t3_full_pop", 64'(fifo_full), 0);
    for (int j = 0; j < 32; j++) frame($sformatf("t3_f%0d", j), pat(j));
    check("t3_busy_end", 64'(busy), 0);
    check("t3_empty_end", 64'(fifo_empty), 1);
    check("t3_ovf_sticky", 64'(overflow), 1);

    // Reset in the middle of the data bits
    csr_write(12'h050, 8'hE1, 1'b1);
    tick();
    for (int j = 0; j < 3; j++) csr_write(12'h050, pat(j + 40), 1'b1);
    repeat (7) tick();
    check("t6_tx_data", 64'(tx), 64'(1'(8'hE1 >> 1)));
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("t6_tx", 64'(tx), 1);
    check("t6_busy", 64'(busy), 0);
    check("t6_level", 64'(fifo_level), 0);
    check("t6_empty", 64'(fifo_empty), 1);
    check("t6_ovf", 64'(overflow), 0);
    repeat (3) tick();
    check("t6_tx_idle", 64'(tx), 1);
    check("t6_busy_idle", 64'(busy), 0);

    // Push into a full FIFO on the pop cycle
    csr_write(12'h050, 8'hD0, 1'b1);
    tick();
    for (int j = 0; j < 32; j++) csr_write(12'h050, pat(j + 100), 1'b1);
    check("t4_level_full", 64'(fifo_level), 32);
    check("t4_full", 64'(fifo_full), 1);
    repeat (7) tick();
    csr_write(12'h050, 8'h99, 1'b1);
    check("t4_level", 64'(fifo_level), 32);
    check("t4_full_kept", 64'(fifo_full), 1);
    check("t4_ovf", 64'(overflow), 0);
    for (int j = 0; j < 32; j++) frame($sformatf("t4_f%0d", j), pat(j + 100));
    frame("t4_f99", 8'h99);
    check("t4_busy_end", 64'(busy), 0);
    check("t4_empty_end", 64'(fifo_empty), 1);

    // Odd-weight byte (parity bit is 1 when enabled)
    csr_write(12'h050, 8'h07, 1'b1);
    tick();
    frame("t7_07", 8'h07);
    check("t7_busy_end", 64'(busy), 0);
    check("t7_tx_end", 64'(tx), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
CSR-mapped UART transmit peripheral: core writes bytes to the UART FIFO CSR (0x50); the block queues them and serialises them 8N1 on the tx pin. It sits directly downstream of the CSR write port and consumes the UART configuration constants (queue size, CSR address, baud compare value). It exposes fill level and status for polling or interrupt use.

Parameters:
QueueSize, 32, FIFO depth in bytes; power of two, >= 2
PtrWidth, $clog2(QueueSize) = 5, FIFO pointer width
CsrAddr, 'h50, CSR address whose writes push a byte
CmpVal, 173, clock cycles per UART bit (CoreFreq / UartBaudRate = 20 MHz / 115200)

Ports:
clk  in  1  core clock
reset_n  in  1  synchronous active-low reset
csr_we  in  1  CSR write strobe, one cycle per write
csr_addr  in  12  CSR address of the write
csr_data  in  8  byte to enqueue (bits [7:0] of CSR write data)
tx  out  1  UART serial line, idle high
busy  out  1  frame in progress (state != IDLE)
fifo_full  out  1  count == QueueSize
fifo_empty  out  1  count == 0
fifo_level  out  PtrWidth+1  bytes currently queued
overflow  out  1  sticky: a push was dropped because FIFO full

Behaviour:
- One clock; reset is synchronous and active-low (reset_n sampled on rising clk edge).
- Reset values: tx=1, busy=0, fifo_full=0, fifo_empty=1, fifo_level=0, overflow=0. Pointers, baud counter, bit index and shift register are cleared, and the state machine is set to IDLE.
- Reset mid-frame aborts the frame. tx returns to 1 on the cycle after reset is sampled. Queued data is discarded.
- Push: csr_we && csr_addr==CsrAddr && (!fifo_full || pop this cycle). The byte is written at wr_ptr and wr_ptr increments, wrapping modulo QueueSize. Writes to any other address are ignored.
- Push while full with no pop this cycle: the byte is dropped and overflow is set to 1. overflow is cleared only by reset.
- Pop: occurs when the FSM loads a byte. The byte at rd_ptr goes to the shift register and rd_ptr increments, wrapping.
- Simultaneous push and pop: both take effect and count is unchanged. This also applies when the FIFO is full.
- FIFO outputs (fifo_full, fifo_empty, fifo_level) are registered and reflect the state after the clock edge.
- State machine states:
  - IDLE: tx=1. If !fifo_empty: pop, clear baud counter, go to START.
  - START: tx=0 for CmpVal cycles, then go to DATA with bit index 0.
  - DATA: tx = shift[0] (LSB first) for CmpVal cycles per bit, shifting right after each bit. After bit 7 go to STOP.
  - STOP: tx=1 for CmpVal cycles. At the end of STOP: if !fifo_empty, pop and go directly to START (no idle gap); otherwise go to IDLE.
- Baud counter runs 0..CmpVal-1; a bit period ends when the counter equals CmpVal-1. A frame is exactly 10*CmpVal cycles.
- Latency: a push sampled at edge k with the FIFO empty and FSM in IDLE makes fifo_empty=0 after edge k, pops at edge k+1, and drives tx low after edge k+1.
- tx is driven from a register, so the output is glitch-free.

Optional Feature:
UART_TX_PARITY_EN
- Defined: a PARITY state is inserted between DATA and STOP. For CmpVal cycles it drives even parity, the XOR of the 8 data bits. A frame is 11*CmpVal cycles.
- Undefined: 8N1 only, 10-bit frames, and no PARITY state logic is present.

Test Plan:
1. CmpVal=4. Write 0xA5 to 0x50 from idle -> tx low 2 cycles after the write. Then bits 1,0,1,0,0,1,0,1, each 4 cycles, stop high 4 cycles. busy=1 for 40 cycles.
2. Write 0x55 then 0x0F on consecutive cycles -> fifo_level goes 1, then 1 (pop of the first byte overlaps the second push), then back to 0 after the second pop. Frames are back-to-back with no idle cycles between stop and start. tx=1 afterwards.
3. With the FSM busy, write 33 bytes -> fifo_full=1 at level 32 and overflow=1. The 33rd byte is never transmitted. The 32 bytes transmit in order; the wr_ptr/rd_ptr wrap is exercised.
4. With the FIFO full, write on the exact cycle the FSM pops -> byte accepted, fifo_level stays 32, overflow stays 0.
5. Write to 0x51 and to 0x50 with csr_we=0 -> no push, fifo_empty stays 1, tx stays 1.
6. Assert reset_n=0 for one cycle mid-DATA with 3 bytes queued -> next cycle tx=1, busy=0, fifo_level=0, fifo_empty=1, overflow=0. With UART_TX_PARITY_EN defined, 0x07 produces parity bit 1 and an 11-bit frame.
